// File: rtl/aq_fill_receiver.sv
// Bus-side answer queue for one cache bank: filters response packets by destination ID,
// reassembles 4-beat line fills and buffers them in a show-ahead FIFO for the bank.
module aq_fill_receiver #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   cache_id,
  input  logic         BUS_valid,
  input  logic [31:0]  BUS_data,
  output logic         BUS_ready,
  input  logic         AQ_READ,
  output logic         AQ_isEMPTY,
  output logic         AQ_FULL,
  output logic [14:0]  AQ_pAddress,
  output logic [6:0]   AQ_PTC_ID,
  output logic [127:0] AQ_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StHdr, StD0, StD1, StD2, StD3} state_e;

  state_e           state_q, state_d;
  logic             match_q;
  logic [14:0]      paddr_q;
  logic [6:0]       ptc_q;
  logic [95:0]      line_q;

  logic [14:0]      mem_addr_q [DEPTH];
  logic [6:0]       mem_ptc_q  [DEPTH];
  logic [127:0]     mem_data_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic             xfer, commit, pop, reserved;
  logic [CntW:0]    occupancy;

  // A matching packet in flight already owns a slot, so later headers see it as occupied.
  assign reserved   = (state_q != StHdr) && match_q;
  assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, reserved};
  assign AQ_FULL    = (occupancy == (CntW + 1)'(DEPTH));
  assign AQ_isEMPTY = (count_q == '0);
  assign BUS_ready  = (state_q == StHdr) ? ~AQ_FULL : 1'b1;

  assign xfer   = BUS_valid & BUS_ready;
  assign pop    = AQ_READ & ~AQ_isEMPTY;
  assign commit = xfer && (state_q == StD3) && match_q;

  assign AQ_pAddress = mem_addr_q[rd_ptr_q];
  assign AQ_PTC_ID   = mem_ptc_q[rd_ptr_q];
  assign AQ_data     = mem_data_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      unique case (state_q)
        StHdr:   state_d = StD0;
        StD0:    state_d = StD1;
        StD1:    state_d = StD2;
        StD2:    state_d = StD3;
        StD3:    state_d = StHdr;
        default: state_d = StHdr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHdr;
      match_q <= 1'b0;
      paddr_q <= '0;
      ptc_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        unique case (state_q)
          StHdr: begin
            match_q <= (BUS_data[2:0] == cache_id);
            paddr_q <= BUS_data[17:3];
            ptc_q   <= BUS_data[24:18];
          end
          StD0:    line_q[31:0]  <= BUS_data;
          StD1:    line_q[63:32] <= BUS_data;
          StD2:    line_q[95:64] <= BUS_data;
          default: ;
        endcase
      end
    end
  end

  // Data3 goes straight from the bus into storage; no fourth holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_addr_q[i] <= '0;
        mem_ptc_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (commit) begin
      mem_addr_q[wr_ptr_q] <= paddr_q;
      mem_ptc_q[wr_ptr_q]  <= ptc_q;
      mem_data_q[wr_ptr_q] <= {BUS_data, line_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (commit) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({commit, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule
